// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I constants, types and operand bypass helper
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_COUNT  = 32;
    localparam int ADDR_WIDTH = 5;

    localparam logic [2:0] FUNCT3_ADD  = 3'd0;
    localparam logic [2:0] FUNCT3_SLL  = 3'd1;
    localparam logic [2:0] FUNCT3_SLT  = 3'd2;
    localparam logic [2:0] FUNCT3_SLTU = 3'd3;
    localparam logic [2:0] FUNCT3_XOR  = 3'd4;
    localparam logic [2:0] FUNCT3_SR   = 3'd5;
    localparam logic [2:0] FUNCT3_OR   = 3'd6;
    localparam logic [2:0] FUNCT3_AND  = 3'd7;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    // Write-first read: x0 is always zero, a same-cycle write to the source wins
    function automatic xlen_t bypass_read(
        input reg_addr_t src,
        input logic      wr_en,
        input reg_addr_t wr_addr,
        input xlen_t     wr_data,
        input xlen_t     rf_data
    );
        if (src == '0)
            return '0;
        else if (wr_en && (wr_addr == src))
            return wr_data;
        else
            return rf_data;
    endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// rtl/operand_fetch_stage_if.sv - issue, writeback and ALU-side signal bundle
interface operand_fetch_stage_if;
    import rv32i_pkg::*;

    logic       issue_valid;
    logic       issue_ready;
    reg_addr_t  rs1_addr;
    reg_addr_t  rs2_addr;
    logic [2:0] funct3_in;
    logic       write_enable;
    reg_addr_t  write_addr;
    xlen_t      write_data;
    logic       alu_ready;
    logic       enable;
    logic [2:0] funct3;
    xlen_t      register_data_1;
    xlen_t      register_data_2;

    modport master (
        output issue_valid, rs1_addr, rs2_addr, funct3_in,
        output write_enable, write_addr, write_data, alu_ready,
        input  issue_ready, enable, funct3, register_data_1, register_data_2
    );

    modport slave (
        input  issue_valid, rs1_addr, rs2_addr, funct3_in,
        input  write_enable, write_addr, write_data, alu_ready,
        output issue_ready, enable, funct3, register_data_1, register_data_2
    );

endinterface

// File: rtl/operand_fetch_stage_register_file.sv
// rtl/operand_fetch_stage_register_file.sv - 32x32 register file, two async reads, one sync write
module register_file
    import rv32i_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      write_enable,
    input  reg_addr_t write_addr,
    input  xlen_t     write_data,
    input  reg_addr_t read_addr_1,
    input  reg_addr_t read_addr_2,
    output xlen_t     read_data_1,
    output xlen_t     read_data_2
);

    xlen_t r_regs [0:REG_COUNT-1];

    // Clear every register on reset; otherwise store writes to any register except x0
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++)
                r_regs[i] <= '0;
        end else if (write_enable && (write_addr != '0)) begin
            r_regs[write_addr] <= write_data;
        end
    end

    assign read_data_1 = (read_addr_1 == '0) ? '0 : r_regs[read_addr_1];
    assign read_data_2 = (read_addr_2 == '0) ? '0 : r_regs[read_addr_2];

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - operand fetch with writeback bypass and hold-time refresh
module operand_fetch_stage
    import rv32i_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    operand_fetch_stage_if.slave bus
);

    logic       r_enable;
    logic [2:0] r_funct3;
    xlen_t      r_data_1;
    xlen_t      r_data_2;
    reg_addr_t  r_rs1_addr;
    reg_addr_t  r_rs2_addr;

    xlen_t      w_rf_data_1;
    xlen_t      w_rf_data_2;
    logic       w_write_valid;
    logic       w_issue_ready;
    logic       w_accept;
    logic       w_hold;
    logic       w_refresh_1;
    logic       w_refresh_2;

    register_file u_register_file (
        .clock        (clock),
        .reset_n      (reset_n),
        .write_enable (bus.write_enable),
        .write_addr   (bus.write_addr),
        .write_data   (bus.write_data),
        .read_addr_1  (bus.rs1_addr),
        .read_addr_2  (bus.rs2_addr),
        .read_data_1  (w_rf_data_1),
        .read_data_2  (w_rf_data_2)
    );

    assign w_write_valid = bus.write_enable && (bus.write_addr != '0);
    assign w_issue_ready = !r_enable || bus.alu_ready;
    assign w_accept      = bus.issue_valid && w_issue_ready;
    assign w_hold        = r_enable && !bus.alu_ready;
    // Captured address 0 never refreshes because w_write_valid excludes x0
    assign w_refresh_1   = w_hold && w_write_valid && (bus.write_addr == r_rs1_addr);
    assign w_refresh_2   = w_hold && w_write_valid && (bus.write_addr == r_rs2_addr);

    // Output slot: load on accept, drop enable on drain, patch operands while held
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_enable   <= 1'b0;
            r_funct3   <= '0;
            r_data_1   <= '0;
            r_data_2   <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
        end else if (w_accept) begin
            r_enable   <= 1'b1;
            r_funct3   <= bus.funct3_in;
            r_rs1_addr <= bus.rs1_addr;
            r_rs2_addr <= bus.rs2_addr;
            r_data_1   <= bypass_read(bus.rs1_addr, bus.write_enable, bus.write_addr,
                                      bus.write_data, w_rf_data_1);
            r_data_2   <= bypass_read(bus.rs2_addr, bus.write_enable, bus.write_addr,
                                      bus.write_data, w_rf_data_2);
        end else if (r_enable && bus.alu_ready) begin
            r_enable <= 1'b0;
        end else begin
            if (w_refresh_1)
                r_data_1 <= bus.write_data;
            if (w_refresh_2)
                r_data_2 <= bus.write_data;
        end
    end

    assign bus.issue_ready     = w_issue_ready;
    assign bus.enable          = r_enable;
    assign bus.funct3          = r_funct3;
    assign bus.register_data_1 = r_data_1;
    assign bus.register_data_2 = r_data_2;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - scoreboard bench for operand_fetch_stage
module tb_operand_fetch_stage;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  a1;
        logic [4:0]  a2;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;

    operand_fetch_stage_if bus ();

    operand_fetch_stage dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb_q[$];
    exp_t        m_last;
    logic        m_en;
    logic [31:0] ref_regs [0:31];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0)
            return 32'd0;
        else if (we && wa == a)
            return wd;
        else
            return ref_regs[a];
    endfunction

    task automatic cycle(input logic rst_n, input logic v, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [2:0] f3, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input logic ardy);
        exp_t e;
        logic acc;
        reset_n          = rst_n;
        bus.issue_valid  = v;
        bus.rs1_addr     = a1;
        bus.rs2_addr     = a2;
        bus.funct3_in    = f3;
        bus.write_enable = we;
        bus.write_addr   = wa;
        bus.write_data   = wd;
        bus.alu_ready    = ardy;
        @(negedge clock);
        check("issue_ready", 32'(bus.issue_ready), 32'(!m_en || ardy));
        check("enable", 32'(bus.enable), 32'(m_en));
        if (m_en && sb_q.size() == 0)
            check("sb_size", 32'(sb_q.size()), 32'd1);
        e = (m_en && sb_q.size() > 0) ? sb_q[0] : m_last;
        check("funct3", 32'(bus.funct3), 32'(e.f3));
        check("data_1", bus.register_data_1, e.d1);
        check("data_2", bus.register_data_2, e.d2);
        if (!rst_n) begin
            sb_q.delete();
            m_en   = 1'b0;
            m_last = '0;
            for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        end else begin
            acc = v && (!m_en || ardy);
            if (m_en && ardy) begin
                if (sb_q.size() > 0) m_last = sb_q.pop_front();
            end else if (m_en && we && wa != 5'd0 && sb_q.size() > 0) begin
                e = sb_q[0];
                if (e.a1 == wa) e.d1 = wd;
                if (e.a2 == wa) e.d2 = wd;
                sb_q[0] = e;
            end
            if (acc) begin
                e.f3 = f3;
                e.a1 = a1;
                e.a2 = a2;
                e.d1 = exp_read(a1, we, wa, wd);
                e.d2 = exp_read(a2, we, wa, wd);
                sb_q.push_back(e);
                m_en = 1'b1;
            end else if (m_en && ardy) begin
                m_en = 1'b0;
            end
            if (we && wa != 5'd0) ref_regs[wa] = wd;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic ardy);
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 3'd0, 1'b0, 5'd0, 32'd0, ardy);
    endtask

    initial begin
        m_en   = 1'b0;
        m_last = '0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        reset_n          = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.rs1_addr     = '0;
        bus.rs2_addr     = '0;
        bus.funct3_in    = '0;
        bus.write_enable = 1'b0;
        bus.write_addr   = '0;
        bus.write_data   = '0;
        bus.alu_ready    = 1'b1;
        @(posedge clock);
        #1;

        cycle(1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        cycle(1'b1, 1'b1, 5'd5, 5'd9, 3'd2, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b1);

        cycle(1'b1, 1'b0, 5'd0, 5'd0, 3'd0, 1'b1, 5'd3, 32'h0000_0001, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 3'd0, 1'b1, 5'd4, 32'h0000_0002, 1'b1);
        cycle(1'b1, 1'b1, 5'd3, 5'd4, 3'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b1);

        cycle(1'b1, 1'b0, 5'd0, 5'd0, 3'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1);
        cycle(1'b1, 1'b1, 5'd0, 5'd0, 3'd7, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1);
        idle(1'b1);

        cycle(1'b1, 1'b1, 5'd7, 5'd0, 3'd1, 1'b1, 5'd7, 32'h1234_5678, 1'b1);
        cycle(1'b1, 1'b1, 5'd7, 5'd7, 3'd4, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b1);

        cycle(1'b1, 1'b1, 5'd3, 5'd6, 3'd5, 1'b0, 5'd0, 32'd0, 1'b1);
        cycle(1'b1, 1'b1, 5'd4, 5'd6, 3'd6, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(1'b1, 1'b1, 5'd4, 5'd6, 3'd6, 1'b1, 5'd6, 32'hFFFF_FFFF, 1'b0);
        cycle(1'b1, 1'b1, 5'd4, 5'd6, 3'd6, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(1'b1, 1'b1, 5'd4, 5'd6, 3'd6, 1'b1, 5'd4, 32'hA5A5_0004, 1'b0);
        cycle(1'b1, 1'b1, 5'd4, 5'd6, 3'd6, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom, 1'b1);
        idle(1'b1);

        for (int i = 0; i < 8; i++)
            cycle((i == 4) ? 1'b0 : 1'b1, 1'b1, 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 1'b1,
                  5'($urandom_range(1, 31)), $urandom, 1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
